// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the byte-addressed data memory controller.
//   state_t        : controller FSM states (IDLE, WAIT, DONE)
//   BYTES          : bytes per word for the default 16-bit configuration
//   cnt_width()    : width of the wait-state counter for a given latency
//   bytes_per_word : bytes per word for a given data width
// Optional feature macro used by the controller: MEM_BOUNDS_CHECK_EN
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTES = 2;

  // Counter only ever holds LATENCY-2 down to 0; keep at least one bit.
  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency);
  endfunction

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// 8-bit x DEPTH_BYTES storage with a word-wide write port carrying per-byte
// enables and a registered word-wide read port. Byte i of a word lives at
// addr+i; the index wraps modulo DEPTH_BYTES. Contents are not reset.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (read register only)
//   we    : write strobe, gated per byte by be
//   re    : read strobe, loads rdata
//   addr  : byte address of the lowest byte
//   wdata : little-endian write word
//   be    : per-byte write enables
//   rdata : registered little-endian read word
// -----------------------------------------------------------------------------
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [DATA_W/8-1:0]            be,
  output logic [DATA_W-1:0]              rdata
);

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int AW     = $clog2(DEPTH_BYTES);

  logic [7:0]        mem_r [DEPTH_BYTES];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane writes; addr + i wraps naturally in AW bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (we && be[i]) begin
        mem_r[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read of NBYTES consecutive (wrapping) bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      for (int i = 0; i < NBYTES; i++) begin
        rdata_r[8*i +: 8] <= mem_r[addr + AW'(i)];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/byte_memory_ctrl.sv
// -----------------------------------------------------------------------------
// byte_memory_ctrl
// Byte-addressed data memory with request/ready/valid handshake, configurable
// access latency, per-byte write enables and optional out-of-range detection.
// Accept at edge 0 -> memory access on edge LATENCY-1 (entering DONE) ->
// out_valid for the cycle after edge LATENCY -> out_ready after edge LATENCY+1.
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   : accesses with address+BYTES-1 >= DEPTH_BYTES complete with
//               out_error=1, write nothing and return 0 on out_read
//   undefined : byte addresses wrap modulo DEPTH_BYTES, out_error stays 0
// Ports:
//   inp_clk, inp_rst : clock, synchronous active-high reset
//   inp_req          : request strobe, taken only while out_ready=1
//   inp_memWrite     : 1 = write, 0 = read
//   inp_address      : byte address of lowest byte
//   inp_dataWrite    : little-endian write data
//   inp_byteEn       : per-byte write enables
//   out_ready        : idle, can accept
//   out_valid        : one-cycle completion pulse
//   out_read         : read data, held until the next read completes
//   out_error        : out-of-range flag, qualified by out_valid
// -----------------------------------------------------------------------------
module byte_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 8 * BYTES,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  inp_clk,
  input  logic                  inp_rst,
  input  logic                  inp_req,
  input  logic                  inp_memWrite,
  input  logic [ADDR_W-1:0]     inp_address,
  input  logic [DATA_W-1:0]     inp_dataWrite,
  input  logic [DATA_W/8-1:0]   inp_byteEn,
  output logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_read,
  output logic                  out_error
);

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int CNT_W  = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam bit ONE_CYCLE = (LATENCY == 1);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [AW-1:0]       addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [NBYTES-1:0]   be_r;
  logic                write_r;
  logic                err_r;
  logic                ready_r;
  logic                valid_r;
  logic                error_r;
  logic [DATA_W-1:0]   read_r;

  logic                accept_s;
  logic                commit_s;
  logic                err_s;
  logic [AW-1:0]       cur_addr_s;
  logic [DATA_W-1:0]   cur_wdata_s;
  logic [NBYTES-1:0]   cur_be_s;
  logic                cur_write_s;
  logic                cur_err_s;
  logic                arr_we_s;
  logic                arr_re_s;
  logic [DATA_W-1:0]   arr_rdata_s;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] LAST_OFF = (ADDR_W + 1)'(NBYTES - 1);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH_BYTES);
  // Extra MSB keeps the sum from wrapping before the compare.
  assign err_s = (({1'b0, inp_address} + LAST_OFF) >= DEPTH_X);
`else
  // Upper address bits are don't-care when addresses wrap.
  logic unused_addr_s;
  assign unused_addr_s = ^inp_address;
  assign err_s         = 1'b0;
`endif

  assign accept_s = inp_req && ready_r;

  // With LATENCY=1 the access happens on the accept edge, so it must use the
  // live request fields; otherwise it uses the values latched at accept.
  always_comb begin
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    cur_be_s    = be_r;
    cur_write_s = write_r;
    cur_err_s   = err_r;
    if (state_r == IDLE) begin
      cur_addr_s  = inp_address[AW-1:0];
      cur_wdata_s = inp_dataWrite;
      cur_be_s    = inp_byteEn;
      cur_write_s = inp_memWrite;
      cur_err_s   = err_s;
    end else begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
      cur_write_s = write_r;
      cur_err_s   = err_r;
    end
  end

  // Access fires on the edge entering DONE; reset on that edge aborts it.
  assign commit_s = !inp_rst &&
                    ((ONE_CYCLE && (state_r == IDLE) && accept_s) ||
                     ((state_r == WAIT) && (cnt_r == '0)));
  assign arr_we_s = commit_s && cur_write_s && !cur_err_s;
  assign arr_re_s = commit_s && !cur_write_s;

  mem_byte_array #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk   (inp_clk),
    .rst   (inp_rst),
    .we    (arr_we_s),
    .re    (arr_re_s),
    .addr  (cur_addr_s),
    .wdata (cur_wdata_s),
    .be    (cur_be_s),
    .rdata (arr_rdata_s)
  );

  // Controller FSM, request latches and registered outputs.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
      write_r <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      error_r <= 1'b0;
      read_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (accept_s) begin
            addr_r  <= inp_address[AW-1:0];
            wdata_r <= inp_dataWrite;
            be_r    <= inp_byteEn;
            write_r <= inp_memWrite;
            err_r   <= err_s;
            ready_r <= 1'b0;
            cnt_r   <= CNT_LOAD;
            state_r <= ONE_CYCLE ? DONE : WAIT;
          end else begin
            // Ready re-rises one cycle after the valid pulse.
            ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r == '0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          valid_r <= 1'b1;
          error_r <= err_r;
          if (!write_r) begin
            read_r <= err_r ? '0 : arr_rdata_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign out_ready = ready_r;
  assign out_valid = valid_r;
  assign out_read  = read_r;
  assign out_error = error_r;

endmodule

// File: tb/tb_byte_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_memory_ctrl
// Table-driven bench for byte_memory_ctrl with three instances (LATENCY 1, 2,
// 4) sharing the request fields; sel routes req and observed outputs.
// Honours MEM_BOUNDS_CHECK_EN for the top-of-memory expectations.
// -----------------------------------------------------------------------------
module tb_byte_memory_ctrl;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  int          sel;

  logic        req1, req2, req4;
  logic        ready1, ready2, ready4;
  logic        valid1, valid2, valid4;
  logic        error1, error2, error4;
  logic [15:0] read1, read2, read4;

  logic        m_ready, m_valid, m_error;
  logic [15:0] m_read;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign req1 = req && (sel == 1);
  assign req2 = req && (sel == 2);
  assign req4 = req && (sel == 4);

  always_comb begin
    case (sel)
      1:       begin m_ready = ready1; m_valid = valid1; m_error = error1; m_read = read1; end
      4:       begin m_ready = ready4; m_valid = valid4; m_error = error4; m_read = read4; end
      default: begin m_ready = ready2; m_valid = valid2; m_error = error2; m_read = read2; end
    endcase
  end

  byte_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
    .inp_clk(clk), .inp_rst(rst), .inp_req(req1), .inp_memWrite(wr),
    .inp_address(addr), .inp_dataWrite(wdata), .inp_byteEn(be),
    .out_ready(ready1), .out_valid(valid1), .out_read(read1), .out_error(error1));

  byte_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(1024), .LATENCY(2)) dut2 (
    .inp_clk(clk), .inp_rst(rst), .inp_req(req2), .inp_memWrite(wr),
    .inp_address(addr), .inp_dataWrite(wdata), .inp_byteEn(be),
    .out_ready(ready2), .out_valid(valid2), .out_read(read2), .out_error(error2));

  byte_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(1024), .LATENCY(4)) dut4 (
    .inp_clk(clk), .inp_rst(rst), .inp_req(req4), .inp_memWrite(wr),
    .inp_address(addr), .inp_dataWrite(wdata), .inp_byteEn(be),
    .out_ready(ready4), .out_valid(valid4), .out_read(read4), .out_error(error4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b, input logic [15:0] er, input logic ee);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.be = b; v.exp_rd = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One transaction on the selected instance, checking handshake timing.
  // Called at a negedge; returns at the negedge after edge lat+2.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] b, input int lat, input string tag,
                         output logic [15:0] rd, output logic er);
    int guard;
    int first_v;
    int n_v;
    logic rdy_l;
    logic rdy_l1;
    guard = 0;
    while (!m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!m_ready) chk({tag, "_ready_timeout"}, {31'd0, m_ready}, 32'd1);
    wr = w; addr = a; wdata = d; be = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    first_v = -1; n_v = 0; rd = 16'h0; er = 1'b0; rdy_l = 1'b1; rdy_l1 = 1'b0;
    for (int c = 0; c <= lat + 2; c++) begin
      if (c > 0) @(negedge clk);
      if (m_valid) begin
        n_v++;
        if (first_v < 0) begin
          first_v = c;
          rd = m_read;
          er = m_error;
        end
      end
      if (c == lat)     rdy_l  = m_ready;
      if (c == lat + 1) rdy_l1 = m_ready;
    end
    chk({tag, "_valid_edge"}, first_v, lat);
    chk({tag, "_valid_width"}, n_v, 32'd1);
    chk({tag, "_ready_busy"}, {31'd0, rdy_l}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, rdy_l1}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    logic [15:0] last_rd;
    int          n_v;

    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0; be = 2'b00; sel = 2;

    add(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
    add(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
    add(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000, 1'b0);
    add(1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0000, 1'b0);
    add(1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34, 1'b0);
    add(1'b1, 16'h0030, 16'h0066, 2'b11, 16'h0000, 1'b0);
    add(1'b1, 16'h0031, 16'hCAFE, 2'b11, 16'h0000, 1'b0);
    add(1'b0, 16'h0030, 16'h0000, 2'b00, 16'hFE66, 1'b0);
    add(1'b0, 16'h0031, 16'h0000, 2'b00, 16'hCAFE, 1'b0);
    add(1'b1, 16'h0020, 16'h00CD, 2'b01, 16'h0000, 1'b0);
    add(1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD, 1'b0);
    add(1'b1, 16'h0050, 16'h1357, 2'b11, 16'h0000, 1'b0);
    add(1'b1, 16'h0050, 16'h9999, 2'b00, 16'h0000, 1'b0);
    add(1'b0, 16'h0050, 16'h0000, 2'b00, 16'h1357, 1'b0);
    add(1'b1, 16'h0000, 16'h2222, 2'b11, 16'h0000, 1'b0);
    add(1'b1, 16'h03FE, 16'h3344, 2'b11, 16'h0000, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    add(1'b1, 16'h03FF, 16'h5A11, 2'b11, 16'h0000, 1'b1);
    add(1'b0, 16'h03FE, 16'h0000, 2'b00, 16'h3344, 1'b0);
    add(1'b0, 16'h0000, 16'h0000, 2'b00, 16'h2222, 1'b0);
    add(1'b0, 16'h03FF, 16'h0000, 2'b00, 16'h0000, 1'b1);
`else
    add(1'b1, 16'h03FF, 16'h5A11, 2'b11, 16'h0000, 1'b0);
    add(1'b0, 16'h03FE, 16'h0000, 2'b00, 16'h1144, 1'b0);
    add(1'b0, 16'h0000, 16'h0000, 2'b00, 16'h225A, 1'b0);
    add(1'b0, 16'h03FF, 16'h0000, 2'b00, 16'h5A11, 1'b0);
`endif
    add(1'b1, 16'h0040, 16'h1111, 2'b11, 16'h0000, 1'b0);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, m_ready}, 32'd1);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_read",  {16'd0, m_read},  32'd0);
    chk("rst_error", {31'd0, m_error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table on the LATENCY=2 instance; writes must leave out_read untouched.
    last_rd = 16'h0000;
    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, 2,
              $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d_error", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_read_hold", i), {16'd0, rd}, {16'd0, last_rd});
      end else begin
        chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
        last_rd = vecs[i].exp_rd;
      end
    end

    // Request pulsed while busy is dropped; data is latched at accept.
    wr = 1'b1; addr = 16'h0060; wdata = 16'h0A0A; be = 2'b11; req = 1'b1;
    @(negedge clk);
    wdata = 16'hFFFF;
    n_v = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) req = 1'b0;
      if (m_valid) n_v++;
      @(negedge clk);
    end
    chk("busy_req_valid_count", n_v, 32'd1);
    run_txn(1'b0, 16'h0060, 16'h0000, 2'b00, 2, "busy_rd", rd, er);
    chk("busy_rd_data", {16'd0, rd}, 32'h0A0A);

    // Reset one cycle after accepting a write aborts it.
    wr = 1'b1; addr = 16'h0040; wdata = 16'hFFFF; be = 2'b11; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, m_ready}, 32'd1);
    chk("abort_read",  {16'd0, m_read},  32'd0);
    n_v = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_valid) n_v++;
      @(negedge clk);
    end
    chk("abort_no_valid", n_v, 32'd0);
    run_txn(1'b0, 16'h0040, 16'h0000, 2'b00, 2, "abort_rd", rd, er);
    chk("abort_rd_data", {16'd0, rd}, 32'h1111);

    // Same write/read on the LATENCY=1 and LATENCY=4 instances.
    sel = 1;
    run_txn(1'b1, 16'h0010, 16'hBEEF, 2'b11, 1, "lat1_wr", rd, er);
    run_txn(1'b0, 16'h0010, 16'h0000, 2'b00, 1, "lat1_rd", rd, er);
    chk("lat1_rd_data", {16'd0, rd}, 32'hBEEF);
    sel = 4;
    run_txn(1'b1, 16'h0010, 16'hBEEF, 2'b11, 4, "lat4_wr", rd, er);
    run_txn(1'b0, 16'h0010, 16'h0000, 2'b00, 4, "lat4_rd", rd, er);
    chk("lat4_rd_data", {16'd0, rd}, 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
